// File: rtl/spn_cipher_core_if.sv
// spn_cipher_core_if: load/plaintext/key request and ciphertext result bundle for spn_cipher_core.
interface spn_cipher_core_if;
    logic        load;
    logic [31:0] data_in;
    logic [63:0] key_in;
    logic        busy;
    logic [31:0] ct_out;
    logic        ct_valid;
    modport master (output load, data_in, key_in, input busy, ct_out, ct_valid);
    modport slave  (input load, data_in, key_in, output busy, ct_out, ct_valid);
endinterface

// File: rtl/spn_cipher_core.sv
// spn_cipher_core: iterative 32-bit block / 64-bit key SPN cipher (PRESENT s-box), one round per clk.
// Define UNROLL2_EN to chain two rounds per clock; ROUNDS must then be even.
module spn_cipher_core #(
    parameter int ROUNDS = 16
) (
    input logic              clk,
    input logic              reset,
    spn_cipher_core_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, WHITEN} state_t;
    localparam logic [63:0] SBOX = 64'h21748FE3DA09B65C;
    state_t state_q, state_d;
    logic [31:0] s_q, s_d, ct_q, ct_d, s_n;
    logic [63:0] k_q, k_d, k_n;
    logic [4:0] rnd_q, rnd_d;
    logic ctv_q, ctv_d, last;

    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("ROUNDS must be in 1..31");
    end

    function automatic logic [95:0] round(input logic [31:0] s, input logic [63:0] k, input logic [4:0] i);
        logic [31:0] x;
        logic [63:0] kr;
        x = s ^ k[63:32];
        for (int n = 0; n < 8; n++) x[4*n +: 4] = SBOX[4*x[4*n +: 4] +: 4];
        kr = {k[50:0], k[63:51]};
        kr[4:0] = kr[4:0] ^ (i + 5'd1);
        return {x[23:0], x[31:24], kr};
    endfunction

`ifdef UNROLL2_EN
    localparam int STEP = 2;
    logic [31:0] s_m;
    logic [63:0] k_m;
    if (ROUNDS % 2 != 0) begin : g_odd_rounds
        $error("ROUNDS must be even when unrolled");
    end
    assign {s_m, k_m} = round(s_q, k_q, rnd_q);
    assign {s_n, k_n} = round(s_m, k_m, rnd_q + 5'd1);
`else
    localparam int STEP = 1;
    assign {s_n, k_n} = round(s_q, k_q, rnd_q);
`endif

    assign last = rnd_q == 5'(ROUNDS - STEP);

    always_comb begin
        state_d = state_q;
        s_d = s_q;
        k_d = k_q;
        rnd_d = rnd_q;
        ct_d = ct_q;
        ctv_d = 1'b0;
        case (state_q)
            IDLE: if (bus.load) begin
                state_d = RUN;
                s_d = bus.data_in;
                k_d = bus.key_in;
                rnd_d = '0;
            end
            RUN: begin
                s_d = s_n;
                k_d = k_n;
                rnd_d = rnd_q + 5'(STEP);
                state_d = last ? WHITEN : RUN;
            end
            WHITEN: begin
                ct_d = s_q ^ k_q[63:32];
                ctv_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            s_q <= '0;
            k_q <= '0;
            rnd_q <= '0;
            ct_q <= '0;
            ctv_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q <= s_d;
            k_q <= k_d;
            rnd_q <= rnd_d;
            ct_q <= ct_d;
            ctv_q <= ctv_d;
        end
    end

    assign bus.busy = state_q != IDLE;
    assign bus.ct_out = ct_q;
    assign bus.ct_valid = ctv_q;
endmodule

// File: tb/tb_spn_cipher_core.sv
// tb_spn_cipher_core: directed vectors on a 16-round core and a minimal-round core, plus load/reset corner sequences.
module tb_spn_cipher_core;
`ifdef UNROLL2_EN
    localparam int SR = 2;
    localparam int LAT16 = 9;
`else
    localparam int SR = 1;
    localparam int LAT16 = 17;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic load = 1'b0;
    logic [31:0] data = '0;
    logic [63:0] key = '0;
    int tests = 0;
    int fails = 0;
    logic [3:0] sb [16];

    spn_cipher_core_if b16();
    spn_cipher_core_if b1();
    assign b16.load = load;
    assign b16.data_in = data;
    assign b16.key_in = key;
    assign b1.load = load;
    assign b1.data_in = data;
    assign b1.key_in = key;

    spn_cipher_core #(.ROUNDS(16)) dut16 (.clk(clk), .reset(reset), .bus(b16.slave));
    spn_cipher_core #(.ROUNDS(SR)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [63:0] k;
        logic [31:0] exp1;
    } vec_t;
    vec_t vt [6];

    function automatic logic [31:0] model(input logic [31:0] d, input logic [63:0] k, input int r);
        logic [31:0] s, x;
        logic [63:0] kk;
        s = d;
        kk = k;
        for (int i = 0; i < r; i++) begin
            x = s ^ kk[63:32];
            for (int n = 0; n < 8; n++) x[n*4 +: 4] = sb[x[n*4 +: 4]];
            s = (x << 8) | (x >> 24);
            kk = (kk << 13) | (kk >> 51);
            kk = kk ^ 64'(i + 1);
        end
        return s ^ kk[63:32];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_wait();
        load = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic run_vec(input logic [31:0] d, input logic [63:0] k, input logic [31:0] e1);
        int t1 = -1, t16 = -1, n1 = 0, n16 = 0, nb = 0;
        logic [31:0] c1 = 'x, c16 = 'x;
        @(negedge clk);
        load = 1'b1;
        data = d;
        key = k;
        @(negedge clk);
        load = 1'b0;
        data = $urandom;
        key = {$urandom, $urandom};
        if (b16.busy) nb++;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (b16.busy) nb++;
            if (b1.ct_valid) begin n1++; if (t1 < 0) t1 = n; c1 = b1.ct_out; end
            if (b16.ct_valid) begin n16++; if (t16 < 0) t16 = n; c16 = b16.ct_out; end
        end
        check("lat_small", 64'(t1), 64'(2));
        check("lat16", 64'(t16), 64'(LAT16));
        check("pulses_small", 64'(n1), 64'd1);
        check("pulses16", 64'(n16), 64'd1);
        check("busy16_cycles", 64'(nb), 64'(LAT16));
        check("ct_small", 64'(c1), 64'((SR == 1) ? e1 : model(d, k, SR)));
        check("ct16", 64'(c16), 64'(model(d, k, 16)));
    endtask

    initial begin
        int n16, gap;
        logic [31:0] c16;
        sb = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
               4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        vt[0] = '{32'h00000000, 64'h00000000_00000000, 32'hCCCCCCCC};
        vt[1] = '{32'h00000000, 64'hFFFFFFFF_00000000, 32'hDDDDC222};
        vt[2] = '{32'hFFFFFFFF, 64'h00000000_00000000, 32'h22222222};
        vt[3] = '{32'h01234567, 64'h00000000_00000000, 32'h6B90ADC5};
        vt[4] = '{32'h00000000, 64'h00000000_FFFFFFFF, 32'hCCCCD333};
        vt[5] = '{32'h89ABCDEF, 64'h00000000_00000000, 32'hF847123E};
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(b16.busy), 64'd0);
        check("rst_ct_out", 64'(b16.ct_out), 64'd0);
        check("rst_ct_valid", 64'(b16.ct_valid), 64'd0);
        reset = 1'b0;
        for (int v = 0; v < 6; v++) run_vec(vt[v].d, vt[v].k, vt[v].exp1);
        // load spammed while busy: only the first block is processed
        idle_wait();
        load = 1'b1;
        data = 32'hDEADBEEF;
        key = 64'h01234567_89ABCDEF;
        @(negedge clk);
        n16 = 0;
        c16 = 'x;
        for (int n = 0; n < 40; n++) begin
            load = b16.busy;
            data = $urandom;
            key = {$urandom, $urandom};
            @(negedge clk);
            if (b16.ct_valid) begin n16++; c16 = b16.ct_out; end
        end
        check("spam_pulses", 64'(n16), 64'd1);
        check("spam_ct", 64'(c16), 64'(model(32'hDEADBEEF, 64'h01234567_89ABCDEF, 16)));
        // load held high: second block accepted in the ct_valid cycle
        idle_wait();
        load = 1'b1;
        data = 32'hA5A5A5A5;
        key = 64'hFEDCBA98_76543210;
        @(negedge clk);
        data = 32'h3C3C0FF0;
        key = 64'h13579BDF_2468ACE0;
        c16 = 'x;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (b16.ct_valid) begin c16 = b16.ct_out; break; end
        end
        check("held_ct_a", 64'(c16), 64'(model(32'hA5A5A5A5, 64'hFEDCBA98_76543210, 16)));
        @(negedge clk);
        load = 1'b0;
        check("held_busy_b", 64'(b16.busy), 64'd1);
        gap = -1;
        c16 = 'x;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (b16.ct_valid) begin gap = n; c16 = b16.ct_out; break; end
        end
        check("held_lat_b", 64'(gap), 64'(LAT16));
        check("held_ct_b", 64'(c16), 64'(model(32'h3C3C0FF0, 64'h13579BDF_2468ACE0, 16)));
        // reset in the middle of a block aborts it
        idle_wait();
        load = 1'b1;
        data = 32'h12345678;
        key = 64'hCAFEF00D_BAADC0DE;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", 64'(b16.busy), 64'd0);
        check("abort_ct_out", 64'(b16.ct_out), 64'd0);
        n16 = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (b16.ct_valid) n16++;
        end
        check("abort_no_valid", 64'(n16), 64'd0);
        check("abort_ct_hold", 64'(b16.ct_out), 64'd0);
        run_vec(32'h12345678, 64'hCAFEF00D_BAADC0DE, model(32'h12345678, 64'hCAFEF00D_BAADC0DE, 1));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
